// File: rtl/a_wport_arb_pkg.sv
// Shared definitions for the A-register write-port arbiter.
package a_wport_arb_pkg;

  localparam int AIDX_W = 3;  // A-register index width
  localparam int A_NREG = 8;  // number of A registers

  // Source of an A-file write as seen on o_a_src.
  typedef enum logic {
    A_SRC_FU  = 1'b0,
    A_SRC_MEM = 1'b1
  } a_src_e;

endpackage

// File: rtl/a_wport_fifo.sv
// Synchronous FIFO with push/pop, empty/full.
// Pointers wrap modulo DEPTH (a power of two).
// A push while full is dropped unless a pop happens in the same cycle.
module a_wport_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  // Qualify requests against occupancy.
  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rp];
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (do_pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/a_wport_arb.sv
// A-register file write-port arbiter: merges fixed-latency FU results with
// in-order memory load returns. It also keeps the load reservation mask.
// Optional macro A_WPORT_BYPASS_EN: a return arriving with the FIFO empty
// and no FU write is written next cycle without being queued.
module a_wport_arb
  import a_wport_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fu_we,
  input  logic [AIDX_W-1:0] i_fu_dest,
  input  logic [AW-1:0]     i_fu_data,
  input  logic              i_ld_issue,
  input  logic [AIDX_W-1:0] i_ld_dest,
  input  logic              i_mem_vld,
  input  logic [AW-1:0]     i_mem_data,
  output logic              o_a_we,
  output logic [AIDX_W-1:0] o_a_dest,
  output logic [AW-1:0]     o_a_data,
  output logic              o_a_src,
  output logic [A_NREG-1:0] o_ld_res_mask,
  output logic              o_ld_ok,
  output logic              o_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     out_cnt;    // issued, not yet written to the file
  logic [CW-1:0]     await_cnt;  // issued, data not yet returned
  logic [A_NREG-1:0] mask_nxt;
  logic [AIDX_W-1:0] dq_head;
  logic [AW-1:0]     df_head;
  logic              dq_empty, dq_full, df_empty, df_full;
  logic              issue_ok, issue_bad, stray, mem_acc, bypass;
  logic              df_push, df_pop, mem_wr, overflow;

  // Issue qualification, return acceptance and port arbitration.
  always_comb begin
    o_ld_ok   = (out_cnt < CW'(DEPTH)) && !o_ld_res_mask[i_ld_dest] && !dq_full;
    issue_ok  = i_ld_issue && o_ld_ok;
    issue_bad = i_ld_issue && !o_ld_ok;
    stray     = i_mem_vld && (await_cnt == '0);
    mem_acc   = i_mem_vld && !stray;
`ifdef A_WPORT_BYPASS_EN
    bypass    = mem_acc && df_empty && !i_fu_we;
`else
    bypass    = 1'b0;
`endif
    df_push   = mem_acc && !bypass;
    df_pop    = !i_fu_we && !df_empty;
    mem_wr    = !i_fu_we && (!df_empty || bypass);
    overflow  = df_push && df_full && !df_pop;
    // The retiring head is reserved and an issue needs an unreserved dest,
    // so the clear and set always hit different bits.
    mask_nxt  = o_ld_res_mask;
    if (mem_wr)   mask_nxt[dq_head]   = 1'b0;
    if (issue_ok) mask_nxt[i_ld_dest] = 1'b1;
  end

  // Registered write port, reservation state and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_a_we        <= 1'b0;
      o_a_dest      <= '0;
      o_a_data      <= '0;
      o_a_src       <= A_SRC_FU;
      o_ld_res_mask <= '0;
      o_err         <= 1'b0;
      out_cnt       <= '0;
      await_cnt     <= '0;
    end else begin
      o_a_we <= i_fu_we || mem_wr;
      if (i_fu_we) begin
        o_a_dest <= i_fu_dest;
        o_a_data <= i_fu_data;
        o_a_src  <= A_SRC_FU;
      end else if (mem_wr) begin
        o_a_dest <= dq_head;
        o_a_data <= bypass ? i_mem_data : df_head;
        o_a_src  <= A_SRC_MEM;
      end
      o_ld_res_mask <= mask_nxt;
      out_cnt       <= out_cnt + CW'(issue_ok) - CW'(mem_wr);
      await_cnt     <= await_cnt + CW'(issue_ok) - CW'(mem_acc);
      if (issue_bad || stray || overflow) o_err <= 1'b1;
    end
  end

  a_wport_fifo #(.W(AIDX_W), .DEPTH(DEPTH)) u_dest_q (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_ok),
    .din   (i_ld_dest),
    .pop   (mem_wr),
    .dout  (dq_head),
    .empty (dq_empty),
    .full  (dq_full)
  );

  a_wport_fifo #(.W(AW), .DEPTH(DEPTH)) u_data_q (
    .clk   (clk),
    .rst   (rst),
    .push  (df_push),
    .din   (i_mem_data),
    .pop   (df_pop),
    .dout  (df_head),
    .empty (df_empty),
    .full  (df_full)
  );

  // Dest queue is never empty when a write is selected; kept for visibility.
  logic dq_empty_unused;
  assign dq_empty_unused = dq_empty;

endmodule

// File: doc/a_wport_arb.md
# a_wport_arb

Arbiter and sequencer for the single write port of the A-register file. It merges two sources. The first is fixed-latency A functional-unit results delivered by the A scheduler's result pipeline. The second is variable-latency memory-load returns destined for Ai, which are buffered in issue order. The block also keeps the load reservation mask that the issue logic uses to block reads and writes of Ai registers still awaiting memory data.

## Interface
- DEPTH, 4, max outstanding A-register loads; also the return-FIFO depth; power of two, 2..16
- AW, 24, A-register data width
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- i_fu_we  in  1  A functional-unit result valid this cycle
- i_fu_dest  in  3  FU result destination Ai
- i_fu_data  in  AW  FU result data
- i_ld_issue  in  1  load to Ai issued this cycle; legal only when o_ld_ok
- i_ld_dest  in  3  destination Ai of the load being checked or issued
- i_mem_vld  in  1  memory return data valid; returns arrive in issue order, cannot be stalled
- i_mem_data  in  AW  memory return data
- o_a_we  out  1  A-file write enable (registered)
- o_a_dest  out  3  A-file write address (registered)
- o_a_data  out  AW  A-file write data (registered)
- o_a_src  out  1  source of the current write: 0 FU, 1 memory (registered)
- o_ld_res_mask  out  8  one-hot-per-register mask of Ai awaiting load data (registered)
- o_ld_ok  out  1  combinational: outstanding<DEPTH && !o_ld_res_mask[i_ld_dest]
- o_err  out  1  sticky protocol error (registered)

## Operation
- Destination queue: on i_ld_issue, push i_ld_dest and set o_ld_res_mask[i_ld_dest]. The outstanding count increments.
- Data FIFO: on i_mem_vld, push i_mem_data.
- Pairing: the data-FIFO head always pairs with the dest-queue head, because returns are in order.
- Port priority: the FU path always wins because its timing is fixed.
  - If i_fu_we: the write is the FU data, src=0.
  - Else if the data FIFO is non-empty: pop the data head and dest head, write them, src=1, and clear the mask bit for that dest.
- The memory write and the mask clear take effect on the same clock edge. The outstanding count decrements on that edge.
- Simultaneous issue and retire: count unchanged. The set and clear bits are necessarily different registers, so both apply.
- Simultaneous i_mem_vld and pop: push and pop in the same cycle; FIFO occupancy unchanged.
- FIFO full cannot legitimately overflow, because the outstanding count covers both queued and in-flight loads.
- i_mem_vld with zero outstanding returns: data dropped, o_err set.
- i_ld_issue while o_ld_ok=0: the issue is ignored and o_err is set.
- o_err clears only on rst.
- Reset mid-operation: queues, count and mask are cleared. Later stray memory returns are dropped and raise o_err.
- FIFO pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - o_a_we=0, o_a_dest=0, o_a_data=0, o_a_src=0
  - o_ld_res_mask=0, o_err=0
  - o_ld_ok=1 (count 0, mask 0)
- FU path: i_fu_we in cycle N gives o_a_we=1 in cycle N+1. Latency 1, never delayed.
- Memory path: i_mem_vld in cycle N is enqueued at the end of N and is eligible in N+1. It reaches o_a_we in N+2 if no FU write occurs in N+1.
- Each FU write in a cycle where the memory path is eligible delays it by one cycle.
- Mask bit: set in cycle N+1 after an issue in N. Cleared in the same cycle the memory write appears on o_a_we.
- o_a_we is a one-cycle pulse per write.

## Configuration
- A_WPORT_BYPASS_EN defined: when i_mem_vld, the FIFO is empty and i_fu_we=0, the data bypasses the FIFO.
  - It is written in N+1 (latency 1) and the dest queue is popped that same cycle.
- A_WPORT_BYPASS_EN undefined: all returns pass through the FIFO (latency 2 minimum).

## Structure
- Shared package/header: the A-register index width (3), A register count (8), and the o_a_src encodings (A_SRC_FU=0, A_SRC_MEM=1).
- Sub-module a_wport_fifo: a synchronous FIFO parameterised by width and depth, with push, pop, empty and full. It is instantiated twice: once for dest (3 bits) and once for data (AW bits).

## Test plan
- FU only: i_fu_we, dest 3, data 0x00ABCD in cycle 5 -> o_a_we=1, dest 3, data 0x00ABCD, src 0 in cycle 6.
- Single load:
  - Issue to A2 in cycle 1 -> mask=0x04 in cycle 2.
  - Return 0x123456 in cycle 10 -> write A2, src 1, in cycle 12 (cycle 11 with bypass); mask=0 in that same cycle.
- Collision: return eligible in cycle 12 with FU writes in cycles 11 and 12 -> memory write deferred to cycle 14.
- Capacity:
  - 4 issues to A1..A4 -> o_ld_ok=0 with count 4.
  - A further issue -> ignored, o_err=1.
  - Returns retire in order A1, A2, A3, A4.
- Reservation: A5 reserved, i_ld_dest=5 -> o_ld_ok=0; i_ld_dest=6 -> o_ld_ok=1.
- Reset mid-op: 2 loads outstanding, rst for 1 cycle -> mask 0, o_ld_ok=1. A subsequent i_mem_vld -> no write, o_err=1.
